// File: rtl/counter_pkg.sv
// counter_pkg: constants shared by the button debouncer and the 4-bit up-counter it feeds.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM_HIGH = 2'd1,
        ST_HELD     = 2'd2,
        ST_ARM_LOW  = 2'd3
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_REPEAT_DELAY    = 8;
    localparam int DEFAULT_REPEAT_PERIOD   = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
// Synchronous active-low reset with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so sync_q takes meta_q's value from before this edge.
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/step_debouncer.sv
// step_debouncer: synchronises and debounces a push button into a one-cycle step pulse and a level.
// Define STEP_DEBOUNCER_AUTO_REPEAT_EN to add auto-repeat steps while the button stays held.
module step_debouncer
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step,
    output logic level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Repeat settings below 2 could pulse step on back-to-back cycles.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("step_debouncer: parameter out of legal range");
    end

    logic             btn_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             level_q, level_d;
    logic             press_accept;
    logic             rpt_fire;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_accept = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_ARM_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_ARM_HIGH: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_HELD;
                    cnt_d        = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_ARM_LOW;
                    cnt_d   = '0;
                end
            end
            ST_ARM_LOW: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef STEP_DEBOUNCER_AUTO_REPEAT_EN
    localparam int               RPT_MAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                                : REPEAT_PERIOD;
    localparam int               RPT_W         = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;

    // Down-counter: loaded on every entry to HELD, fires on reaching zero while HELD persists.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q != ST_HELD && state_d == ST_HELD) begin
            rpt_d = RPT_DELAY_LD;
        end else if (state_q == ST_HELD && state_d == ST_HELD) begin
            if (rpt_q == '0) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_PERIOD_LD;
            end else begin
                rpt_d = rpt_q - RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        level_d = (state_d == ST_HELD) || (state_d == ST_ARM_LOW);
        step_d  = press_accept || rpt_fire;
    end

    assign step  = step_q;
    assign level = level_q;

endmodule

// File: tb/tb_step_debouncer.sv
// tb_step_debouncer: directed self-checking bench for step_debouncer (N=4, delay 8, period 4).
// Expectations follow STEP_DEBOUNCER_AUTO_REPEAT_EN when the bench is built with it.
module tb_step_debouncer;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic step;
    logic level;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         step_edges[$];
    logic [3:0] dn_cnt    = 4'd0;
    logic       prev_step = 1'b0;
    logic       b2b_seen  = 1'b0;

    step_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .step    (step),
        .level   (level)
    );

    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Records the edge index of every step and models the downstream 4-bit counter.
    always @(negedge clk) begin
        if (step === 1'b1) step_edges.push_back(cyc);
        if (rst_n === 1'b0)    dn_cnt <= 4'd0;
        else if (step === 1'b1) dn_cnt <= dn_cnt + 4'd1;
        if (step === 1'b1 && prev_step === 1'b1) b2b_seen <= 1'b1;
        prev_step <= step;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n falling edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, l0, r, rel, base;
        int exp_rel[$];

        rst_n   = 1'b0;
        btn_raw = 1'b0;
        tick(2);
        check("rst_step", step, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_level", level, 0);

        // Clean press: step and level after e0+6, single step, no step on release.
        base    = step_edges.size();
        btn_raw = 1'b1;
        e0      = cyc + 1;
        tick(6);
        check("t1_level_early", level, 0);
        check("t1_step_early", step, 0);
        tick(1);
        check("t1_step", step, 1);
        check("t1_level", level, 1);
        tick(1);
        check("t1_step_one_cycle", step, 0);
        tick(3);
        btn_raw = 1'b0;
        rel     = cyc + 1;
        tick(6);
        check("t1_level_before_release", level, 1);
        tick(1);
        check("t1_level_released", level, 0);
        tick(3);
        check("t1_step_count", step_edges.size() - base, 1);
        check("t1_step_edge", step_edges[base] - e0, 6);
        check("t1_dn_cnt", dn_cnt, 1);
        check("t1_rel_ref", cyc - rel, 9);

        // Short high glitch is rejected; stable press from e0 gives one step after e0+6.
        base    = step_edges.size();
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(1);
        btn_raw = 1'b1;
        e0      = cyc + 1;
        tick(6);
        check("t2_level_early", level, 0);
        check("t2_no_glitch_step", step_edges.size() - base, 0);
        tick(1);
        check("t2_step", step, 1);
        check("t2_level", level, 1);
        check("t2_step_edge", step_edges[base] - e0, 6);

        // Low glitch while HELD keeps level high without a step; real release drops level.
        tick(1);
        btn_raw = 1'b0;
        l0      = cyc + 1;
        tick(2);
        btn_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check($sformatf("t3_level_hold_%0d", i), level, 1);
        end
        check("t3_no_regrab_step", step_edges.size() - base, 1);
        btn_raw = 1'b0;
        e1      = cyc + 1;
        tick(6);
        check("t3_level_before_release", level, 1);
        tick(1);
        check("t3_level_released", level, 0);
        tick(3);
        check("t3_no_release_step", step_edges.size() - base, 1);
        check("t3_glitch_ref", e1 - l0, 8);

        // Reset in ARM_HIGH with count 2; held button re-debounces from the first edge after reset.
        base    = step_edges.size();
        btn_raw = 1'b1;
        e0      = cyc + 1;
        tick(5);
        rst_n = 1'b0;
        r     = cyc + 1;
        tick(1);
        check("t4_rst_step", step, 0);
        check("t4_rst_level", level, 0);
        rst_n = 1'b1;
        tick(6);
        check("t4_level_early", level, 0);
        check("t4_no_early_step", step_edges.size() - base, 0);
        tick(1);
        check("t4_step", step, 1);
        check("t4_level", level, 1);
        check("t4_step_edge", step_edges[base] - r, 7);
        check("t4_press_ref", r - e0, 5);
        btn_raw = 1'b0;
        tick(10);
        check("t4_level_released", level, 0);
        check("t4_step_count", step_edges.size() - base, 1);

        // 16 clean presses; downstream counter counts 0..15 and wraps to 0.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t5_dn_reset", dn_cnt, 0);
        base = step_edges.size();
        for (int p = 1; p <= 16; p++) begin
            btn_raw = 1'b1;
            tick(12);
            btn_raw = 1'b0;
            tick(12);
            if (p == 2) begin
                check("t5_two_steps", step_edges.size() - base, 2);
                check("t5_dn_two", dn_cnt, 2);
            end
            if (p == 15) check("t5_dn_fifteen", dn_cnt, 15);
            if (p == 16) begin
                check("t5_sixteen_steps", step_edges.size() - base, 16);
                check("t5_dn_wrap", dn_cnt, 0);
            end
        end

        // Long hold: auto-repeat steps when enabled, otherwise exactly one step.
`ifdef STEP_DEBOUNCER_AUTO_REPEAT_EN
        exp_rel = '{6, 14, 18, 22, 26, 30};
`else
        exp_rel = '{6};
`endif
        base    = step_edges.size();
        btn_raw = 1'b1;
        e0      = cyc + 1;
        tick(32);
        btn_raw = 1'b0;
        tick(12);
        check("t6_step_count", step_edges.size() - base, exp_rel.size());
        for (int i = 0; i < exp_rel.size(); i++) begin
            check($sformatf("t6_step_edge_%0d", i), step_edges[base + i] - e0, exp_rel[i]);
        end
        check("t6_level_released", level, 0);

        check("no_back_to_back_step", b2b_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
